// File: rtl/uart_host_if_pkg.sv
// Shared types for the UART host-side buffer.
// TX FSM encoding and default FIFO address width.
package uart_host_if_pkg;

    localparam int AW_DEF = 4;

    typedef enum logic [1:0] {
        T_IDLE   = 2'd0,
        T_SEND   = 2'd1,
        T_WAITHI = 2'd2,
        T_WAITLO = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_host_if_if.sv
// Host-side bus of the UART buffer block.
// master = CPU/bus side, slave = uart_host_if.
interface uart_host_bus_if
    import uart_host_if_pkg::*;
#(
    parameter int AW = AW_DEF
);
    logic [7:0]  HOST_WDATA;
    logic        HOST_WE;
    logic        TX_FULL;
    logic [AW:0] TX_LEVEL;
    logic [7:0]  HOST_RDATA;
    logic        HOST_RE;
    logic        RX_EMPTY;
    logic [AW:0] RX_LEVEL;
    logic        RX_OVF;
    logic        OVF_CLR;

    modport master (
        output HOST_WDATA, HOST_WE, HOST_RE, OVF_CLR,
        input  TX_FULL, TX_LEVEL, HOST_RDATA,
        input  RX_EMPTY, RX_LEVEL, RX_OVF
    );

    modport slave (
        input  HOST_WDATA, HOST_WE, HOST_RE, OVF_CLR,
        output TX_FULL, TX_LEVEL, HOST_RDATA,
        output RX_EMPTY, RX_LEVEL, RX_OVF
    );
endinterface

// File: rtl/uart_host_if_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Pointers carry an extra wrap bit for full/empty.
module uart_sync_fifo #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RESETB,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    localparam int DEPTH = 2**AW;

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Advance pointers; push and pop are independent.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/uart_host_if.sv
// Host-side TX/RX buffering for the rs232c core.
// TX FSM paces the core, RX side acks each byte.
module uart_host_if
    import uart_host_if_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic       CLK,
    input  logic       RESETB,
    uart_host_bus_if.slave host,
    output logic [7:0] TX_DATA,
    output logic       TX_DATA_EN,
    input  logic       TX_BUSY,
    input  logic [7:0] RX_DATA,
    input  logic       RX_DATA_RDY,
    output logic       RX_DATA_RD
);
    tx_state_t  tx_state;
    logic       tx_empty;
    logic       tx_pop;
    logic [7:0] tx_head;
    logic       rx_full;
    logic       rx_pop;
    logic       rx_full_nx;
    logic       rx_ovf;

    assign tx_pop = (tx_state == T_IDLE) && !tx_empty && !TX_BUSY;

    assign rx_pop     = host.HOST_RE && !host.RX_EMPTY;
    assign rx_full_nx = rx_full && !rx_pop;
    assign host.RX_OVF = rx_ovf;

    uart_sync_fifo #(.AW(AW), .DW(8)) u_tx_fifo (
        .CLK    (CLK),
        .RESETB (RESETB),
        .push   (host.HOST_WE),
        .wdata  (host.HOST_WDATA),
        .pop    (tx_pop),
        .rdata  (tx_head),
        .full   (host.TX_FULL),
        .empty  (tx_empty),
        .level  (host.TX_LEVEL)
    );

    uart_sync_fifo #(.AW(AW), .DW(8)) u_rx_fifo (
        .CLK    (CLK),
        .RESETB (RESETB),
        .push   (RX_DATA_RD),
        .wdata  (RX_DATA),
        .pop    (host.HOST_RE),
        .rdata  (host.HOST_RDATA),
        .full   (rx_full),
        .empty  (host.RX_EMPTY),
        .level  (host.RX_LEVEL)
    );

    // TX FSM: hand one byte to the core, then wait out its busy time.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            tx_state   <= T_IDLE;
            TX_DATA    <= 8'h00;
            TX_DATA_EN <= 1'b0;
        end else begin
            TX_DATA_EN <= 1'b0;
            unique case (tx_state)
                T_IDLE: begin
                    if (tx_pop) begin
                        TX_DATA    <= tx_head;
                        TX_DATA_EN <= 1'b1;
                        tx_state   <= T_SEND;
                    end
                end
                T_SEND:   tx_state <= T_WAITHI;
                T_WAITHI: tx_state <= T_WAITLO;
                T_WAITLO: begin
                    if (!TX_BUSY) tx_state <= T_IDLE;
                end
                default:  tx_state <= T_IDLE;
            endcase
        end
    end

    // One-cycle ack; skip the cycle after an ack while RDY drops.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            RX_DATA_RD <= 1'b0;
        end else begin
            RX_DATA_RD <= RX_DATA_RDY && !rx_full_nx && !RX_DATA_RD;
        end
    end

    // Sticky overflow: byte pending with no room; set beats clear.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            rx_ovf <= 1'b0;
        end else if (RX_DATA_RDY && rx_full_nx) begin
            rx_ovf <= 1'b1;
        end else if (host.OVF_CLR) begin
            rx_ovf <= 1'b0;
        end
    end
endmodule
